// File: rtl/ecc_modmul_seq_if.sv
// Request/response bundle for the sequential modular multiplier.
// Carries the operands, curve constants and the busy/done/product handshake.
interface ecc_modmul_seq_if;
  typedef struct packed {
    logic [255:0] p;
  } curve_parameters_t;

  logic              start;
  logic [255:0]      a;
  logic [255:0]      b;
  curve_parameters_t params;
  logic              busy;
  logic              done;
  logic [255:0]      product;

  modport master (output start, a, b, params, input busy, done, product);
  modport slave  (input start, a, b, params, output busy, done, product);
endinterface

// File: rtl/ecc_modmul_seq.sv
// Sequential a*b mod p using MSB-first interleaved double-and-add on a single
// shared modular add/sub unit; no multiplier array.
module add (
  input  logic [255:0] i_a,
  input  logic [255:0] i_b,
  input  logic         i_op,
  input  logic [255:0] i_p,
  output logic [255:0] o_r
);
  logic         w_cy;
  logic [255:0] w_s;
  logic         w_bw;
  logic [255:0] w_d;
  logic         w_nb;
  logic [255:0] w_df;
  logic [255:0] w_df_fix;

  // 257-bit sum, then conditional subtract of p decided by the borrow out.
  assign {w_cy, w_s} = {1'b0, i_a} + {1'b0, i_b};
  assign {w_bw, w_d} = {w_cy, w_s} - {1'b0, i_p};
  assign {w_nb, w_df} = {1'b0, i_a} - {1'b0, i_b};
  assign w_df_fix = w_df + i_p;

  always_comb begin
    o_r = w_bw ? w_s : w_d;
    if (i_op) o_r = w_nb ? w_df_fix : w_df;
  end
endmodule

module ecc_modmul_seq #(
  parameter bit SKIP_ZERO = 1'b0
) (
  input logic              clk,
  input logic              reset_n,
  ecc_modmul_seq_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, DBL, ADD, FIN} state_t;

  state_t       r_state;
  logic [255:0] r_r;
  logic [255:0] r_a_q;
  logic [255:0] r_b_q;
  logic [255:0] r_p_q;
  logic [255:0] r_product;
  logic [7:0]   r_idx;
  logic         r_busy;
  logic         r_done;

  logic         w_bit;
  logic [255:0] w_opb;
  logic [255:0] w_sum;

  assign w_bit = r_b_q[r_idx];

  // DBL adds r to itself; ADD adds a_q or zero depending on the scanned bit.
  always_comb begin
    w_opb = r_r;
    if (r_state == ADD) w_opb = w_bit ? r_a_q : '0;
  end

  add u_add (
    .i_a  (r_r),
    .i_b  (w_opb),
    .i_op (1'b0),
    .i_p  (r_p_q),
    .o_r  (w_sum)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_r       <= '0;
      r_a_q     <= '0;
      r_b_q     <= '0;
      r_p_q     <= '0;
      r_product <= '0;
      r_idx     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_a_q   <= bus.a;
            r_b_q   <= bus.b;
            r_p_q   <= bus.params.p;
            r_r     <= '0;
            r_idx   <= 8'd255;
            r_busy  <= 1'b1;
            r_state <= DBL;
          end
        end
        DBL: begin
          r_r <= w_sum;
          if (!SKIP_ZERO || w_bit) begin
            r_state <= ADD;
          end else if (r_idx == 8'd0) begin
            // Result is captured on the edge entering FIN so it is valid with done.
            r_product <= w_sum;
            r_done    <= 1'b1;
            r_state   <= FIN;
          end else begin
            r_idx <= r_idx - 8'd1;
          end
        end
        ADD: begin
          r_r <= w_sum;
          if (r_idx == 8'd0) begin
            r_product <= w_sum;
            r_done    <= 1'b1;
            r_state   <= FIN;
          end else begin
            r_idx   <= r_idx - 8'd1;
            r_state <= DBL;
          end
        end
        FIN: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.product = r_product;
endmodule

// File: tb/tb_ecc_modmul_seq.sv
// Directed bench for ecc_modmul_seq: fixed- and variable-latency instances,
// checking products, cycle counts, start handling and mid-run reset.
module tb_ecc_modmul_seq;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  ecc_modmul_seq_if bus0 ();
  ecc_modmul_seq_if bus1 ();

  ecc_modmul_seq #(.SKIP_ZERO(1'b0)) dut0 (.clk(clk), .reset_n(reset_n), .bus(bus0));
  ecc_modmul_seq #(.SKIP_ZERO(1'b1)) dut1 (.clk(clk), .reset_n(reset_n), .bus(bus1));

  localparam logic [255:0] P256 =
    256'hFFFFFFFF00000001000000000000000000000000FFFFFFFFFFFFFFFFFFFFFFFF;
  localparam logic [255:0] P256_HALF_UP =
    256'h7FFFFFFF80000000800000000000000000000000800000000000000000000000;
  localparam int unsigned BOUND = 1100;

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int which, input logic st,
                       input logic [255:0] a, input logic [255:0] b, input logic [255:0] p);
    if (which == 0) begin
      bus0.start = st; bus0.a = a; bus0.b = b; bus0.params.p = p;
    end else begin
      bus1.start = st; bus1.a = a; bus1.b = b; bus1.params.p = p;
    end
  endtask

  function automatic logic get_done(input int which);
    return (which == 0) ? bus0.done : bus1.done;
  endfunction

  function automatic logic get_busy(input int which);
    return (which == 0) ? bus0.busy : bus1.busy;
  endfunction

  function automatic logic [255:0] get_prod(input int which);
    return (which == 0) ? bus0.product : bus1.product;
  endfunction

  // Counts negedges after the accepting edge until done is seen.
  task automatic wait_done(input int which, output int lat);
    lat = 0;
    while (!get_done(which) && lat < int'(BOUND)) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_op(input int which, input logic [255:0] a, input logic [255:0] b,
                        input logic [255:0] p, input int exp_lat,
                        input logic [255:0] exp_prod, input string tag);
    int lat;
    @(negedge clk);
    drive(which, 1'b1, a, b, p);
    @(negedge clk);
    chk({tag, "_busy_rise"}, {255'd0, get_busy(which)}, 256'd1);
    drive(which, 1'b0, ~a, ~b, '1);
    wait_done(which, lat);
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_product"}, get_prod(which), exp_prod);
    @(negedge clk);
    chk({tag, "_done_once"}, {255'd0, get_done(which)}, 256'd0);
    chk({tag, "_busy_fall"}, {255'd0, get_busy(which)}, 256'd0);
    chk({tag, "_product_held"}, get_prod(which), exp_prod);
  endtask

  initial begin
    int lat;
    bit saw_done;
    drive(0, 1'b0, '0, '0, 256'd23);
    drive(1, 1'b0, '0, '0, 256'd23);
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {255'd0, bus0.busy}, 256'd0);
    chk("rst_done", {255'd0, bus0.done}, 256'd0);
    chk("rst_product", bus0.product, 256'd0);
    chk("rst_busy_skip", {255'd0, bus1.busy}, 256'd0);
    reset_n = 1'b1;

    // Fixed latency: 512 compute edges regardless of operand values.
    run_op(0, 256'd5, 256'd7, 256'd23, 512, 256'd12, "p23_5x7");
    run_op(0, P256 - 256'd1, P256 - 256'd1, P256, 512, 256'd1, "p256_m1sq");
    run_op(0, 256'd2, P256_HALF_UP, P256, 512, 256'd1, "p256_inv2");
    run_op(0, 256'h1234, 256'd0, P256, 512, 256'd0, "b_zero");
    run_op(0, 256'd0, P256 - 256'd1, P256, 512, 256'd0, "a_zero");

    // start held high: one op per IDLE visit, restart at E514 with new operands.
    @(negedge clk);
    drive(0, 1'b1, 256'd5, 256'd7, 256'd23);
    @(negedge clk);
    chk("hold_busy_rise", {255'd0, bus0.busy}, 256'd1);
    drive(0, 1'b1, 256'd6, 256'd6, 256'd23);
    wait_done(0, lat);
    chk("hold_latency", lat, 512);
    chk("hold_product", bus0.product, 256'd12);
    @(negedge clk);
    chk("hold_idle_gap", {255'd0, bus0.busy}, 256'd0);
    @(negedge clk);
    chk("hold_restart", {255'd0, bus0.busy}, 256'd1);
    drive(0, 1'b0, 256'd1, 256'd1, 256'd23);
    wait_done(0, lat);
    chk("hold2_latency", lat, 512);
    chk("hold2_product", bus0.product, 256'd13);
    @(negedge clk);
    chk("hold2_busy_fall", {255'd0, bus0.busy}, 256'd0);

    // Reset asserted for one edge at cycle 200 of a run.
    @(negedge clk);
    drive(0, 1'b1, 256'd5, 256'd7, 256'd23);
    @(negedge clk);
    drive(0, 1'b0, 256'd5, 256'd7, 256'd23);
    repeat (199) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    chk("midrst_busy", {255'd0, bus0.busy}, 256'd0);
    chk("midrst_done", {255'd0, bus0.done}, 256'd0);
    chk("midrst_product", bus0.product, 256'd0);
    saw_done = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (bus0.done) saw_done = 1'b1;
    end
    chk("midrst_no_done", {255'd0, saw_done}, 256'd0);
    run_op(0, 256'd3, 256'd4, 256'd23, 512, 256'd12, "midrst_fresh");

    // Variable latency: 256 + popcount(b).
    run_op(1, 256'd5, 256'd1, 256'd23, 257, 256'd5, "skip_b1");
    run_op(1, 256'd5, 256'd3, 256'd23, 258, 256'd15, "skip_b3");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
